// File: rtl/seven_segment_scan_if.sv
// Bus between the multiplexed seven-segment scanner and its surroundings.
// master: drives enable, display_data, decimal_digit; observes the scan outputs.
// slave : the scanner itself.
//   enable        - high runs the scan, low darkens the display and holds state
//   display_data  - high selects the blinking "Hi" message, low the temperature
//   decimal_digit - digit code for the position currently on select
//   select        - position being fetched (00 'C', 01 fraction, 10 ones, 11 tens)
//   segments      - active-low {g,f,e,d,c,b,a}
//   dp            - active-low decimal point
//   digit_en      - active-low anodes, bit n drives position n
interface seven_segment_scan_if;
  logic       enable;
  logic       display_data;
  logic [3:0] decimal_digit;
  logic [1:0] select;
  logic [6:0] segments;
  logic       dp;
  logic [3:0] digit_en;

  modport master (
    output enable, display_data, decimal_digit,
    input  select, segments, dp, digit_en
  );

  modport slave (
    input  enable, display_data, decimal_digit,
    output select, segments, dp, digit_en
  );
endinterface

// File: rtl/seven_segment_scan.sv
// Four-digit multiplexed seven-segment scanner. Each slot of CLK_DIV cycles
// starts with BLANK_CYCLES of dark anodes (ghosting guard), samples the digit
// code for the new position once, then shows it until the next slot tick.
// In message mode the whole display blinks with a half-period of BLINK_SLOTS.
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous active-high reset
//   scan_io - slave side of seven_segment_scan_if (see that file)
module seven_segment_scan #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned BLINK_SLOTS  = 250
) (
  input logic                 clk,
  input logic                 reset,
  seven_segment_scan_if.slave scan_io
);

  localparam int unsigned CntW   = $clog2(CLK_DIV);
  localparam int unsigned BlinkW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  typedef enum logic [1:0] {StBlank, StSample, StShow} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   presc_q, presc_d;
  logic [CntW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              disp_q;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        en_q, en_d;

  logic tick;
  logic disp_fell;

  assign tick      = scan_io.enable && (presc_q == CntW'(CLK_DIV - 1));
  assign disp_fell = disp_q && !scan_io.display_data;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      4'd10:   decode = 7'h46;  // 'C'
      4'd11:   decode = 7'h09;  // 'H'
      4'd12:   decode = 7'h79;  // 'I'
      4'd13:   decode = 7'h7F;  // blank
      default: decode = 7'h3F;  // '-'
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StBlank;
      presc_q       <= '0;
      blank_cnt_q   <= '0;
      sel_q         <= 2'b00;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      disp_q        <= 1'b0;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      en_q          <= 4'hF;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      blank_cnt_q   <= blank_cnt_d;
      sel_q         <= sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      disp_q        <= scan_io.display_data;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      en_q          <= en_d;
    end
  end

  // Next-state logic; everything except the blink reset freezes while disabled
  always_comb begin
    state_d       = state_q;
    blank_cnt_d   = blank_cnt_q;
    presc_d       = presc_q;
    sel_d         = sel_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (scan_io.enable) begin
      presc_d = tick ? '0 : presc_q + CntW'(1);
      if (tick) begin
        // A tick preempts any state, including a pending SAMPLE
        sel_d       = sel_q + 2'd1;
        state_d     = StBlank;
        blank_cnt_d = '0;
      end else begin
        case (state_q)
          StBlank: begin
            if (blank_cnt_q == CntW'(BLANK_CYCLES - 1)) state_d = StSample;
            else blank_cnt_d = blank_cnt_q + CntW'(1);
          end
          StSample: state_d = StShow;
          StShow:   state_d = StShow;
          default:  state_d = StBlank;
        endcase
      end
    end

    if (disp_fell) begin
      // Leaving message mode restarts the blink so re-entry starts lit
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BlinkW'(BLINK_SLOTS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Output logic, registered by the state register
  always_comb begin
    seg_d = seg_q;
    dp_d  = dp_q;
    en_d  = 4'hF;

    if (scan_io.enable && !tick && state_q == StSample) begin
      if (sel_q == 2'b11 && !scan_io.display_data && scan_io.decimal_digit == 4'd0) begin
        seg_d = 7'h7F;  // leading-zero blanking, anode still driven
      end else begin
        seg_d = decode(scan_io.decimal_digit);
      end
      dp_d = !(sel_q == 2'b10 && !scan_io.display_data);
    end

    if (scan_io.enable && state_d == StShow &&
        !(scan_io.display_data && !blink_phase_q)) begin
      en_d = ~(4'b0001 << sel_q);
    end
  end

  assign scan_io.select   = sel_q;
  assign scan_io.segments = seg_q;
  assign scan_io.dp       = dp_q;
  assign scan_io.digit_en = en_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan with CLK_DIV=8, BLANK_CYCLES=2,
// BLINK_SLOTS=2. A small converter model supplies decimal_digit from select.
// Cycle c counts falling edges after reset release; slot = c/8, and within a
// slot the anode is lit for offsets 3..7.
module tb_seven_segment_scan;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] codes [4];
  int checks = 0;
  int errors = 0;

  seven_segment_scan_if bus ();

  always #5 clk = ~clk;

  always_comb bus.decimal_digit = codes[bus.select];

  seven_segment_scan #(
    .CLK_DIV      (8),
    .BLANK_CYCLES (2),
    .BLINK_SLOTS  (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .scan_io (bus)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the falling edge right after reset release (c = 0)
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_codes(input logic [15:0] code_v);
    for (int i = 0; i < 4; i++) codes[i] = code_v[4*i +: 4];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.display_data = 1'b0;
    load_codes(16'h235A);
    cycles(3);
    checks++;
    if (bus.select !== 2'b00) begin
      errors++; $display("FAIL reset_select: got %b expected 00", bus.select);
    end
    checks++;
    if (bus.segments !== 7'h7F) begin
      errors++; $display("FAIL reset_segments: got %h expected 7f", bus.segments);
    end
    checks++;
    if (bus.dp !== 1'b1) begin
      errors++; $display("FAIL reset_dp: got %b expected 1", bus.dp);
    end
    checks++;
    if (bus.digit_en !== 4'hF) begin
      errors++; $display("FAIL reset_digit_en: got %b expected 1111", bus.digit_en);
    end
  endtask

  task automatic test_temperature(input string name, input logic [15:0] code_v,
                                  input logic [27:0] seg_v, input logic [3:0] dp_v);
    logic [1:0] s;
    int j;
    logic [3:0] exp_en;
    int on_cnt [4];
    for (int i = 0; i < 4; i++) on_cnt[i] = 0;
    load_codes(code_v);
    bus.display_data = 1'b0;
    bus.enable = 1'b1;
    pulse_reset();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      s = 2'((c / 8) % 4);
      j = c % 8;
      exp_en = 4'hF;
      if (j >= 3) exp_en[s] = 1'b0;
      if (c < 32) begin
        for (int k = 0; k < 4; k++) if (bus.digit_en[k] === 1'b0) on_cnt[k]++;
      end
      checks++;
      if (bus.select !== s) begin
        errors++; $display("FAIL %s_select c=%0d: got %b expected %b", name, c, bus.select, s);
      end
      checks++;
      if (bus.digit_en !== exp_en) begin
        errors++;
        $display("FAIL %s_digit_en c=%0d: got %b expected %b", name, c, bus.digit_en, exp_en);
      end
      if (j >= 3) begin
        checks++;
        if (bus.segments !== seg_v[7*s +: 7]) begin
          errors++;
          $display("FAIL %s_segments c=%0d: got %h expected %h", name, c, bus.segments,
                   seg_v[7*s +: 7]);
        end
        checks++;
        if (bus.dp !== dp_v[s]) begin
          errors++; $display("FAIL %s_dp c=%0d: got %b expected %b", name, c, bus.dp, dp_v[s]);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (on_cnt[k] != 5) begin
        errors++; $display("FAIL %s_on_cycles digit %0d: got %0d expected 5", name, k, on_cnt[k]);
      end
    end
  endtask

  task automatic test_blink();
    logic [27:0] seg_v;
    logic [1:0] s;
    int j;
    int slot;
    logic [3:0] exp_en;
    seg_v = {7'h7F, 7'h09, 7'h79, 7'h7F};
    load_codes(16'hDBCD);
    bus.display_data = 1'b1;
    bus.enable = 1'b1;
    pulse_reset();
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      slot = c / 8;
      s = 2'(slot % 4);
      j = c % 8;
      exp_en = 4'hF;
      if (j >= 3 && (slot / 2) % 2 == 0) exp_en[s] = 1'b0;
      checks++;
      if (bus.digit_en !== exp_en) begin
        errors++; $display("FAIL blink_digit_en c=%0d: got %b expected %b", c, bus.digit_en, exp_en);
      end
      checks++;
      if (bus.dp !== 1'b1) begin
        errors++; $display("FAIL blink_dp c=%0d: got %b expected 1", c, bus.dp);
      end
      if (j >= 3) begin
        checks++;
        if (bus.segments !== seg_v[7*s +: 7]) begin
          errors++;
          $display("FAIL blink_segments c=%0d: got %h expected %h", c, bus.segments, seg_v[7*s +: 7]);
        end
      end
    end
  endtask

  // Dropping display_data mid-blink restarts the blink lit with a cleared count
  task automatic test_blink_exit();
    load_codes(16'hDBCD);
    bus.display_data = 1'b1;
    bus.enable = 1'b1;
    pulse_reset();
    cycles(27);
    checks++;
    if (bus.digit_en !== 4'hF) begin
      errors++; $display("FAIL blink_exit_dark: got %b expected 1111", bus.digit_en);
    end
    bus.display_data = 1'b0;
    cycles(1);
    checks++;
    if (bus.digit_en !== 4'b0111) begin
      errors++; $display("FAIL blink_exit_temp: got %b expected 0111", bus.digit_en);
    end
    bus.display_data = 1'b1;
    cycles(1);
    checks++;
    if (bus.digit_en !== 4'b0111) begin
      errors++; $display("FAIL blink_exit_phase: got %b expected 0111", bus.digit_en);
    end
    cycles(6);  // c = 35
    checks++;
    if (bus.digit_en !== 4'b1110) begin
      errors++; $display("FAIL blink_exit_count_on: got %b expected 1110", bus.digit_en);
    end
    cycles(8);  // c = 43
    checks++;
    if (bus.digit_en !== 4'hF) begin
      errors++; $display("FAIL blink_exit_count_off: got %b expected 1111", bus.digit_en);
    end
    cycles(16); // c = 59
    checks++;
    if (bus.digit_en !== 4'b0111) begin
      errors++; $display("FAIL blink_exit_count_on2: got %b expected 0111", bus.digit_en);
    end
    bus.display_data = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_codes(16'h235A);
    bus.display_data = 1'b0;
    bus.enable = 1'b1;
    pulse_reset();
    cycles(19);
    checks++;
    if (bus.digit_en !== 4'b1011) begin
      errors++; $display("FAIL reset_mid_pre: got %b expected 1011", bus.digit_en);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.digit_en !== 4'hF || bus.segments !== 7'h7F || bus.dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_async: got en=%b seg=%h dp=%b expected en=1111 seg=7f dp=1",
               bus.digit_en, bus.segments, bus.dp);
    end
    checks++;
    if (bus.select !== 2'b00) begin
      errors++; $display("FAIL reset_mid_select: got %b expected 00", bus.select);
    end
    @(negedge clk);
    reset = 1'b0;
    cycles(2);
    checks++;
    if (bus.digit_en !== 4'hF) begin
      errors++; $display("FAIL reset_mid_blank: got %b expected 1111", bus.digit_en);
    end
    cycles(1);
    checks++;
    if (bus.digit_en !== 4'b1110 || bus.segments !== 7'h46) begin
      errors++;
      $display("FAIL reset_mid_first: got en=%b seg=%h expected en=1110 seg=46",
               bus.digit_en, bus.segments);
    end
  endtask

  task automatic test_enable();
    load_codes(16'h235A);
    bus.display_data = 1'b0;
    bus.enable = 1'b1;
    pulse_reset();
    cycles(20);
    bus.enable = 1'b0;
    cycles(1);
    checks++;
    if (bus.digit_en !== 4'hF) begin
      errors++; $display("FAIL enable_dark: got %b expected 1111", bus.digit_en);
    end
    cycles(19);
    checks++;
    if (bus.select !== 2'b10 || bus.digit_en !== 4'hF) begin
      errors++;
      $display("FAIL enable_hold: got sel=%b en=%b expected sel=10 en=1111", bus.select, bus.digit_en);
    end
    bus.enable = 1'b1;
    cycles(1);
    checks++;
    if (bus.digit_en !== 4'b1011) begin
      errors++; $display("FAIL enable_resume: got %b expected 1011", bus.digit_en);
    end
    cycles(2);
    checks++;
    if (bus.select !== 2'b10) begin
      errors++; $display("FAIL enable_remaining: got %b expected 10", bus.select);
    end
    cycles(1);
    checks++;
    if (bus.select !== 2'b11 || bus.digit_en !== 4'hF) begin
      errors++;
      $display("FAIL enable_tick: got sel=%b en=%b expected sel=11 en=1111", bus.select, bus.digit_en);
    end
  endtask

  task automatic test_show_stable();
    load_codes(16'h235A);
    bus.display_data = 1'b0;
    bus.enable = 1'b1;
    pulse_reset();
    cycles(4);
    codes[0] = 4'd8;
    cycles(1);
    checks++;
    if (bus.segments !== 7'h46) begin
      errors++; $display("FAIL show_stable_hold: got %h expected 46", bus.segments);
    end
    cycles(6);  // c = 11
    checks++;
    if (bus.segments !== 7'h12) begin
      errors++; $display("FAIL show_stable_next: got %h expected 12", bus.segments);
    end
    cycles(24); // c = 35
    checks++;
    if (bus.segments !== 7'h00) begin
      errors++; $display("FAIL show_stable_resample: got %h expected 00", bus.segments);
    end
  endtask

  initial begin
    test_reset();
    test_temperature("temp_23_5", 16'h235A, {7'h24, 7'h30, 7'h12, 7'h46}, 4'b1011);
    test_temperature("temp_07_0", 16'h070A, {7'h7F, 7'h78, 7'h40, 7'h46}, 4'b1011);
    test_blink();
    test_blink_exit();
    test_reset_mid();
    test_enable();
    test_show_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
